// File: rtl/hook_pkg.sv
// hook_pkg: shared state type and screen/angle constants for the hook controller
package hook_pkg;
  typedef enum logic [1:0] {SWING = 2'd0, EXTEND = 2'd1, RETRACT = 2'd2} hook_state_t;
  localparam int HALF_PI = 64;
  localparam int PI = 128;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
endpackage

// File: rtl/hook_tip_calc.sv
// hook_tip_calc: registered polar-to-screen conversion of the hook tip
module hook_tip_calc #(
  parameter int PIVOT_X = 320,
  parameter int PIVOT_Y = 40,
  parameter int RESET_Y = 71
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  sin,
  input  logic        sinIsNegative,
  input  logic [7:0]  cos,
  input  logic        cosIsNegative,
  input  logic [9:0]  len,
  output logic [10:0] hookX,
  output logic [10:0] hookY
);
  logic [10:0] dx, dy;
  // rope projections: 10x8 unsigned product, keep the integer part
  always_comb begin
    dx = 11'((18'(len) * 18'(cos)) >> 8);
    dy = 11'((18'(len) * 18'(sin)) >> 8);
  end
  // register the tip; negative values wrap as 11-bit two's complement
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hookX <= 11'(PIVOT_X);
      hookY <= 11'(RESET_Y);
    end else begin
      hookX <= cosIsNegative ? 11'(PIVOT_X) - dx : 11'(PIVOT_X) + dx;
      hookY <= sinIsNegative ? 11'(PIVOT_Y) - dy : 11'(PIVOT_Y) + dy;
    end
  end
endmodule

// File: rtl/hook_controller.sv
// hook_controller: pendulum sweep, rope extend/retract FSM and hook tip output
module hook_controller import hook_pkg::*; #(
  parameter int PIVOT_X       = 320,
  parameter int PIVOT_Y       = 40,
  parameter int MIN_LEN       = 32,
  parameter int MAX_LEN       = 400,
  parameter int MIN_ANGLE     = 8,
  parameter int MAX_ANGLE     = 120,
  parameter int SWING_STEP    = 1,
  parameter int EXTEND_SPEED  = 4,
  parameter int RETRACT_SPEED = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fireKey,
  input  logic        grabHit,
  input  logic [1:0]  loadWeight,
  input  logic [7:0]  sin,
  input  logic        sinIsNegative,
  input  logic [7:0]  cos,
  input  logic        cosIsNegative,
  output logic [7:0]  angle,
  output logic [10:0] hookX,
  output logic [10:0] hookY,
  output logic [9:0]  ropeLength,
  output hook_state_t hookState,
  output logic        hookReturned,
  output logic        returnedLoaded
);
  localparam logic [10:0] MinLen = 11'(MIN_LEN);
  localparam logic [10:0] MaxLen = 11'(MAX_LEN);
  logic fireQ, fireReq, loaded, swingUp, fireEdge, offScreen;
  logic [8:0] angUp, angDown;
  logic [10:0] lenUp, lenDown, stepRaw, step;
  hook_tip_calc #(.PIVOT_X(PIVOT_X), .PIVOT_Y(PIVOT_Y), .RESET_Y(PIVOT_Y + MIN_LEN - 1)) tip (
    .clk(clk), .resetN(resetN), .sin(sin), .sinIsNegative(sinIsNegative),
    .cos(cos), .cosIsNegative(cosIsNegative), .len(ropeLength), .hookX(hookX), .hookY(hookY)
  );
  // candidate next angle/length values and the off-screen test on the unclamped tip
  always_comb begin
    fireEdge = fireKey & ~fireQ;
    angUp = {1'b0, angle} + 9'(SWING_STEP);
    angDown = {1'b0, angle} - 9'(SWING_STEP);
    lenUp = {1'b0, ropeLength} + 11'(EXTEND_SPEED);
    stepRaw = 11'(RETRACT_SPEED) >> (loaded ? loadWeight : 2'd0);
    step = (stepRaw == 11'd0) ? 11'd1 : stepRaw;
    lenDown = ({1'b0, ropeLength} <= MinLen + step) ? MinLen : {1'b0, ropeLength} - step;
    offScreen = hookX[10] | (hookX >= 11'(SCREEN_W)) | ($signed(hookY) >= $signed(11'(SCREEN_H)));
  end
  // hook FSM: sweep while swinging, grow rope on fire, reel it back on grab or limit
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hookState <= SWING;
      angle <= 8'(HALF_PI);
      swingUp <= 1'b1;
      ropeLength <= 10'(MIN_LEN);
      loaded <= 1'b0;
      fireReq <= 1'b0;
      fireQ <= 1'b0;
      hookReturned <= 1'b0;
      returnedLoaded <= 1'b0;
    end else begin
      fireQ <= fireKey;
      hookReturned <= 1'b0;
      case (hookState)
        SWING: begin
          if (fireEdge) fireReq <= 1'b1;
          if (startOfFrame) begin
            if (fireReq) begin
              hookState <= EXTEND;
              fireReq <= 1'b0;
            end else if (swingUp) begin
              angle <= (angUp >= 9'(MAX_ANGLE)) ? 8'(MAX_ANGLE) : angUp[7:0];
              swingUp <= angUp < 9'(MAX_ANGLE);
            end else begin
              angle <= (angDown <= 9'(MIN_ANGLE)) ? 8'(MIN_ANGLE) : angDown[7:0];
              swingUp <= angDown <= 9'(MIN_ANGLE);
            end
          end
        end
        EXTEND: begin
          fireReq <= 1'b0;
          if (startOfFrame) ropeLength <= (lenUp >= MaxLen) ? MaxLen[9:0] : lenUp[9:0];
          if (grabHit) begin
            hookState <= RETRACT;
            loaded <= 1'b1;
          end else if (startOfFrame && (lenUp >= MaxLen || offScreen)) begin
            hookState <= RETRACT;
            loaded <= 1'b0;
          end
        end
        RETRACT: begin
          fireReq <= 1'b0;
          if (startOfFrame) begin
            ropeLength <= lenDown[9:0];
            if (lenDown == MinLen) begin
              hookState <= SWING;
              hookReturned <= 1'b1;
              returnedLoaded <= loaded;
              loaded <= 1'b0;
            end
          end
        end
        default: hookState <= SWING;
      endcase
    end
  end
endmodule

// File: tb/tb_hook_controller.sv
// tb_hook_controller: directed scoreboard bench for the hook controller
`timescale 1ns/1ps
module tb_hook_controller;
  import hook_pkg::*;
  logic clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0, fireKey = 1'b0, grabHit = 1'b0;
  logic [1:0] loadWeight = 2'd0;
  logic [7:0] sin, cos, angle;
  logic sinIsNegative, cosIsNegative, hookReturned, returnedLoaded;
  logic [10:0] hookX, hookY;
  logic [9:0] ropeLength;
  hook_state_t hookState;
  int checks = 0, errors = 0, retCount = 0;
  logic lastLoaded = 1'b0;
  typedef struct {int a; int len; int st; int x; int y;} snap_t;
  snap_t sb[$];
  int mA, mL, mRetCnt = 0;
  logic mUp, mFire, mLoaded, mRetLd = 1'b0;
  hook_state_t mState;

  always #5 clk = ~clk;

  hook_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fireKey(fireKey),
    .grabHit(grabHit), .loadWeight(loadWeight), .sin(sin), .sinIsNegative(sinIsNegative),
    .cos(cos), .cosIsNegative(cosIsNegative), .angle(angle), .hookX(hookX), .hookY(hookY),
    .ropeLength(ropeLength), .hookState(hookState), .hookReturned(hookReturned),
    .returnedLoaded(returnedLoaded)
  );

  function automatic logic [8:0] lut(input logic [7:0] a, input bit useCos);
    real ph, v;
    ph = 3.14159265358979 * real'(a) / real'(PI);
    v = useCos ? $cos(ph) : $sin(ph);
    return {v < 0.0, 8'($rtoi((v < 0.0 ? -v : v) * 255.0 + 0.5))};
  endfunction

  assign {sinIsNegative, sin} = lut(angle, 1'b0);
  assign {cosIsNegative, cos} = lut(angle, 1'b1);

  function automatic int mTipX(input int a, input int l);
    logic [8:0] c;
    int d;
    c = lut(8'(a), 1'b1);
    d = (l * int'(c[7:0])) / 256;
    return c[8] ? (320 - d) & 11'h7FF : 320 + d;
  endfunction

  function automatic int mTipY(input int a, input int l);
    logic [8:0] s;
    int d;
    s = lut(8'(a), 1'b0);
    d = (l * int'(s[7:0])) / 256;
    return s[8] ? (40 - d) & 11'h7FF : 40 + d;
  endfunction

  always @(negedge clk) if (hookReturned) begin
    retCount++;
    lastLoaded = returnedLoaded;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic checkNow(input string tag);
    snap_t s;
    s = '{mA, mL, int'(mState), mTipX(mA, mL), mTipY(mA, mL)};
    sb.push_back(s);
    s = sb.pop_front();
    chk({tag, ".angle"}, 32'(angle), s.a);
    chk({tag, ".len"}, 32'(ropeLength), s.len);
    chk({tag, ".state"}, 32'(hookState), s.st);
    chk({tag, ".hookX"}, 32'(hookX), s.x);
    chk({tag, ".hookY"}, 32'(hookY), s.y);
  endtask

  task automatic modelReset();
    mA = 64; mUp = 1'b1; mL = 32; mState = SWING; mFire = 1'b0; mLoaded = 1'b0;
  endtask

  task automatic modelFrame();
    int n, st;
    case (mState)
      SWING: if (mFire) begin
        mState = EXTEND;
        mFire = 1'b0;
      end else begin
        n = mA + (mUp ? 1 : -1);
        if (n >= 120) begin mA = 120; mUp = 1'b0; end
        else if (n <= 8) begin mA = 8; mUp = 1'b1; end
        else mA = n;
      end
      EXTEND: begin
        mL = (mL + 4 >= 400) ? 400 : mL + 4;
        if (mL == 400) begin mState = RETRACT; mLoaded = 1'b0; end
      end
      default: begin
        st = 4 >> (mLoaded ? int'(loadWeight) : 0);
        if (st == 0) st = 1;
        mL = (mL - st <= 32) ? 32 : mL - st;
        if (mL == 32) begin
          mState = SWING;
          mRetCnt++;
          mRetLd = mLoaded;
          mLoaded = 1'b0;
        end
      end
    endcase
  endtask

  task automatic frame();
    @(negedge clk) startOfFrame = 1'b1;
    @(negedge clk) startOfFrame = 1'b0;
    @(negedge clk);
    modelFrame();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic doReset();
    @(negedge clk) resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    modelReset();
    @(negedge clk);
  endtask

  task automatic fire();
    @(negedge clk) fireKey = 1'b1;
    repeat (2) @(negedge clk);
    fireKey = 1'b0;
    if (mState == SWING) mFire = 1'b1;
    frame();
  endtask

  initial begin
    doReset();
    checkNow("reset");
    chk("reset.hookY", 32'(hookY), 71);
    chk("reset.ret", 32'(hookReturned), 0);
    for (int i = 1; i <= 60; i++) begin
      frame();
      chk("sweep.bound", 32'(angle >= 8 && angle <= 120), 1);
      if (i == 56) chk("sweep.top", 32'(angle), 120);
    end
    checkNow("sweep60");
    chk("sweep60.angle", 32'(angle), 116);

    doReset();
    fire();
    checkNow("fire");
    frames(10);
    checkNow("extend10");
    chk("extend10.len", 32'(ropeLength), 72);
    chk("extend10.hookY", 32'(hookY), 111);
    loadWeight = 2'd2;
    frames(82);
    checkNow("maxLen");
    frames(91);
    @(negedge clk);
    chk("retract.noPulseYet", retCount, 0);
    frame();
    @(negedge clk);
    checkNow("returned");
    chk("returned.count", retCount, mRetCnt);
    chk("returned.loaded", 32'(lastLoaded), 32'(mRetLd));
    chk("returned.loadedConst", 32'(lastLoaded), 0);

    doReset();
    fire();
    frames(17);
    chk("grab.lenBefore", 32'(ropeLength), 100);
    @(negedge clk) grabHit = 1'b1;
    @(negedge clk) grabHit = 1'b0;
    mState = RETRACT;
    mLoaded = 1'b1;
    @(negedge clk);
    checkNow("grab");
    frames(67);
    checkNow("grab67");
    chk("grab67.noPulse", retCount, 1);
    frame();
    @(negedge clk);
    checkNow("grab68");
    chk("grab.count", retCount, 2);
    chk("grab.loaded", 32'(lastLoaded), 1);

    doReset();
    fire();
    frames(5);
    checkNow("midExtend");
    @(negedge clk) resetN = 1'b0;
    #1;
    modelReset();
    checkNow("asyncReset");
    repeat (3) @(negedge clk);
    chk("asyncReset.noPulse", retCount, 2);
    resetN = 1'b1;
    @(negedge clk);
    frame();
    checkNow("afterReset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
